// File: rtl/ahbl_cache_bridge.sv
// AHB-Lite slave that turns single bus transfers into one-cycle read/write
// strobes for a downstream cache controller and waits out its busy handshake.
module ahbl_cache_bridge #(
   parameter int ADDR_WIDTH    = 23,
   parameter bit ERR_UNALIGNED = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_x,
   input  logic                  ahbls_hready,
   output logic                  ahbls_hready_resp,
   output logic                  ahbls_hresp,
   input  logic [31:0]           ahbls_haddr,
   input  logic                  ahbls_hwrite,
   input  logic [1:0]            ahbls_htrans,
   input  logic [2:0]            ahbls_hsize,
   input  logic [31:0]           ahbls_hwdata,
   output logic [31:0]           ahbls_hrdata,
   output logic                  c_rd_en,
   output logic                  c_wr_en,
   output logic [ADDR_WIDTH-1:0] c_addr,
   output logic [31:0]           c_data,
   output logic [3:0]            c_mask,
   input  logic [31:0]           c_rdata,
   input  logic                  c_busy
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_DONE,
      ERR1,
      ERR2
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic                  r_write;
   logic [ADDR_WIDTH-1:0] r_c_addr;
   logic [3:0]            r_c_mask;
   logic [31:0]           r_c_data;
   logic [31:0]           r_hrdata;

   logic                  w_accept;
   logic                  w_invalid;
   logic [1:0]            w_size_eff;
   logic [31:0]           w_addr_al;
   logic [3:0]            w_mask;
   logic                  w_capture;
   logic                  w_unused;

   // Only IDLE doubles as a completion cycle; ERR2 drives HREADYOUT high but
   // deliberately drops whatever address phase coincides with it.
   assign w_accept  = (r_state == IDLE) && ahbls_hready && ahbls_htrans[1];
   assign w_invalid = ERR_UNALIGNED &&
                      ((ahbls_hsize > 3'd2) ||
                       ((ahbls_hsize == 3'd1) && ahbls_haddr[0]) ||
                       ((ahbls_hsize == 3'd2) && (ahbls_haddr[1:0] != 2'b00)));

   assign w_size_eff = (ahbls_hsize > 3'd2) ? 2'd2 : ahbls_hsize[1:0];

   always_comb begin
      case (w_size_eff)
         2'd0:    w_addr_al = ahbls_haddr;
         2'd1:    w_addr_al = {ahbls_haddr[31:1], 1'b0};
         default: w_addr_al = {ahbls_haddr[31:2], 2'b00};
      endcase
   end

   always_comb begin
      case (w_size_eff)
         2'd0:    w_mask = 4'b0001 << w_addr_al[1:0];
         2'd1:    w_mask = w_addr_al[1] ? 4'b1100 : 4'b0011;
         default: w_mask = 4'b1111;
      endcase
   end

   assign w_unused = ^{w_addr_al[31:ADDR_WIDTH+2], ahbls_htrans[0]};

   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // NOTE: every output of this block gets a default before the case so that
   // no path leaves one unassigned and a latch is inferred.
   always_comb begin
      w_next            = r_state;
      ahbls_hready_resp = 1'b1;
      ahbls_hresp       = 1'b0;
      c_rd_en           = 1'b0;
      c_wr_en           = 1'b0;
      w_capture         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = w_invalid ? ERR1 : ISSUE;
            end
         end
         ISSUE: begin
            ahbls_hready_resp = 1'b0;
            if (!c_busy) begin
               c_rd_en = !r_write;
               c_wr_en = r_write;
               w_next  = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            // A write must see busy rise before it may complete.
            ahbls_hready_resp = 1'b0;
            if (c_busy) begin
               w_next = WAIT_DONE;
            end else if (!r_write) begin
               w_capture = 1'b1;
               w_next    = IDLE;
            end
         end
         WAIT_DONE: begin
            ahbls_hready_resp = 1'b0;
            if (!c_busy) begin
               w_capture = !r_write;
               w_next    = IDLE;
            end
         end
         ERR1: begin
            ahbls_hready_resp = 1'b0;
            ahbls_hresp       = 1'b1;
            w_next            = ERR2;
         end
         ERR2: begin
            ahbls_hresp = 1'b1;
            w_next      = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_x) begin
      if (!rst_x) begin
         r_write  <= 1'b0;
         r_c_addr <= '0;
         r_c_mask <= '0;
         r_c_data <= '0;
         r_hrdata <= '0;
      end else begin
         if (w_accept && !w_invalid) begin
            r_write  <= ahbls_hwrite;
            r_c_addr <= w_addr_al[ADDR_WIDTH+1:2];
            r_c_mask <= w_mask;
         end
         if ((r_state == ISSUE) && !c_busy) begin
            r_c_data <= ahbls_hwdata;
         end
         if (w_capture) begin
            r_hrdata <= c_rdata;
         end
      end
   end

   // Write data is passed straight through during ISSUE so it is valid in the
   // same cycle as c_wr_en, then held from the register afterwards.
   assign c_data       = (r_state == ISSUE) ? ahbls_hwdata : r_c_data;
   assign c_addr       = r_c_addr;
   assign c_mask       = r_c_mask;
   assign ahbls_hrdata = r_hrdata;

endmodule
